// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) helpers used by the cipher datapaths.
package aes_pkg;

  localparam int AES128_NR = 10;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} inv_state_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // xtime: multiply by x modulo 0x11b
  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul4(input logic [7:0] b);
    return gf_mul2(gf_mul2(b));
  endfunction

  function automatic logic [7:0] gf_mul8(input logic [7:0] b);
    return gf_mul2(gf_mul4(b));
  endfunction

  // Column-major state: byte index of (row, col)
  function automatic int byte_idx(input int r, input int c);
    return 4 * c + r;
  endfunction

  // 0e*a0 ^ 0b*a1 ^ 0d*a2 ^ 09*a3
  function automatic logic [7:0] inv_mix_byte(input logic [7:0] a0, a1, a2, a3);
    return (gf_mul8(a0) ^ gf_mul4(a0) ^ gf_mul2(a0)) ^ (gf_mul8(a1) ^ gf_mul2(a1) ^ a1) ^
           (gf_mul8(a2) ^ gf_mul4(a2) ^ a2) ^ (gf_mul8(a3) ^ a3);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {inv_mix_byte(a0, a1, a2, a3), inv_mix_byte(a1, a2, a3, a0),
            inv_mix_byte(a2, a3, a0, a1), inv_mix_byte(a3, a0, a1, a2)};
  endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_if.sv
// Ciphertext-in / plaintext-out handshake plus the combinational key-store read port.
interface aes_inv_cipher_iter_if #(parameter int RK_IDX_W = 4);
  logic                in_valid;
  logic                in_ready;
  logic [0:127]        data_in;
  logic [RK_IDX_W-1:0] rk_idx;
  logic [0:127]        rk_data;
  logic                out_valid;
  logic                out_ready;
  logic [0:127]        data_out;

  modport master (output in_valid, data_in, rk_data, out_ready,
                  input  in_ready, rk_idx, out_valid, data_out);
  modport slave  (input  in_valid, data_in, rk_data, out_ready,
                  output in_ready, rk_idx, out_valid, data_out);
endinterface

// File: rtl/aes_inv_round_comb.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns.
module aes_inv_round_comb
  import aes_pkg::*;
(
  input  logic [0:127] state_i,
  input  logic [0:127] rk_i,
  input  logic         bypass_mix_i,
  output logic [0:127] state_o
);

  logic [0:127] sub_s, ark_s, mix_s;

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      // row r rotates right by r: out[r,c] = in[r,(c-r) mod 4]
      localparam int DST = byte_idx(r, c);
      localparam int SRC = byte_idx(r, (c + 4 - r) % 4);
      assign sub_s[8*DST +: 8] = INV_SBOX[state_i[8*SRC +: 8]];
    end
    assign mix_s[32*c +: 32] = inv_mix_col(ark_s[32*c +: 32]);
  end

  assign ark_s   = sub_s ^ rk_i;
  assign state_o = bypass_mix_i ? ark_s : mix_s;

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryptor: one inverse round per clock, round keys read from an external store.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int NR       = 10,
  parameter int RK_IDX_W = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  aes_inv_cipher_iter_if.slave  bus
);

  if (NR != AES128_NR) begin : g_bad_nr
    $error("aes_inv_cipher_iter supports only NR=10");
  end

  localparam logic [RK_IDX_W-1:0] RK_LAST = RK_IDX_W'(NR);
  localparam logic [RK_IDX_W-1:0] RK_ONE  = RK_IDX_W'(1);

  inv_state_e          st_q, st_d;
  logic [0:127]        blk_q, blk_d;
  logic [0:127]        dout_q, dout_d;
  logic [RK_IDX_W-1:0] rk_idx_q, rk_idx_d;
  logic [0:127]        rnd_out;
  logic                last_rnd;

  // rk_idx doubles as the round counter while BUSY
  assign last_rnd = (rk_idx_q == '0);

  aes_inv_round_comb u_round (
    .state_i      (blk_q),
    .rk_i         (bus.rk_data),
    .bypass_mix_i (last_rnd),
    .state_o      (rnd_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= ST_IDLE;
      blk_q    <= '0;
      dout_q   <= '0;
      rk_idx_q <= RK_LAST;
    end else begin
      st_q     <= st_d;
      blk_q    <= blk_d;
      dout_q   <= dout_d;
      rk_idx_q <= rk_idx_d;
    end
  end

  always_comb begin
    st_d     = st_q;
    blk_d    = blk_q;
    dout_d   = dout_q;
    rk_idx_d = rk_idx_q;
    unique case (st_q)
      ST_IDLE: if (bus.in_valid) begin
        blk_d    = bus.data_in ^ bus.rk_data;
        rk_idx_d = RK_LAST - RK_ONE;
        st_d     = ST_BUSY;
      end
      ST_BUSY: if (last_rnd) begin
        // only the final round updates data_out, so a reset never exposes partial state
        dout_d   = rnd_out;
        rk_idx_d = RK_LAST;
        st_d     = ST_DONE;
      end else begin
        blk_d    = rnd_out;
        rk_idx_d = rk_idx_q - RK_ONE;
      end
      ST_DONE: if (bus.out_ready) st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = (st_q == ST_IDLE);
  assign bus.out_valid = (st_q == ST_DONE);
  assign bus.data_out  = dout_q;
  assign bus.rk_idx    = rk_idx_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed + random bench for aes_inv_cipher_iter; reference is an independent forward AES model.
module tb_aes_inv_cipher_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0, n_assert = 0, n_fail = 0, hs_cnt = 0, n_blocks = 0;

  logic [7:0]   sbox [256];
  logic [0:127] rk_sched [11];

  localparam logic [0:127] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  always #5 clk = ~clk;

  aes_inv_cipher_iter_if #(.RK_IDX_W(4)) bus ();
  aes_inv_cipher_iter #(.NR(10), .RK_IDX_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  assign bus.rk_data = (bus.rk_idx <= 4'd10) ? rk_sched[bus.rk_idx] : '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.out_valid && bus.out_ready) hs_cnt <= hs_cnt + 1;
  end

  logic [0:127] rc_state, rc_rk, rc_out;
  logic         rc_bypass;
  aes_inv_round_comb u_rc (.state_i(rc_state), .rk_i(rc_rk), .bypass_mix_i(rc_bypass), .state_o(rc_out));

  task automatic chk(input string tag, input logic [0:127] obs, input logic [0:127] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Forward S-box from the field inverse plus the affine map
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
                {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [0:127] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk_sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [0:127] enc(input logic [0:127] pt);
    logic [0:127] s, u;
    logic [7:0]   a0, a1, a2, a3;
    s = pt ^ rk_sched[0];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          u[8*(4*c+w) +: 8] = sbox[s[8*(4*((c+w)%4)+w) +: 8]];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          {a0, a1, a2, a3} = u[32*c +: 32];
          s[32*c +: 32] = {xt(a0)^xt(a1)^a1^a2^a3, a0^xt(a1)^xt(a2)^a2^a3,
                           a0^a1^xt(a2)^xt(a3)^a3, xt(a0)^a0^a1^a2^xt(a3)};
        end
      end else begin
        s = u;
      end
      s = s ^ rk_sched[r];
    end
    return s;
  endfunction

  // Presents ct once in_ready is seen; t_acc is the cycle whose closing edge accepts it
  task automatic send(input logic [0:127] ct, output int t_acc);
    int g;
    g = 0;
    while (!bus.in_ready && g < 100) begin @(negedge clk); g++; end
    chk("send_in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.data_in  = ct;
    t_acc = cyc;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.data_in  = '0;
  endtask

  task automatic wait_done(output int t_done);
    int g;
    g = 0;
    while (!bus.out_valid && g < 100) begin @(negedge clk); g++; end
    t_done = cyc;
    chk("done_seen", bus.out_valid, 1);
  endtask

  initial begin
    logic [0:127] key, pt, ct;
    int ta, td, ta2, td2;
    bus.in_valid = 1'b0; bus.data_in = '0; bus.out_ready = 1'b0;
    rc_state = '0; rc_rk = '0; rc_bypass = 1'b1;
    for (int r = 0; r <= 10; r++) rk_sched[r] = '0;
    build_sbox();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_data_out", bus.data_out, '0);
    chk("rst_rk_idx", bus.rk_idx, 10);
    rst_n = 1'b1;

    // Round datapath in isolation
    rc_state = {16{8'h63}}; #1 chk("isb_63", rc_out, {16{8'h00}});
    rc_state = {16{8'h7c}}; #1 chk("isb_7c", rc_out, {16{8'h01}});
    for (int i = 0; i < 16; i++) rc_state[8*i +: 8] = sbox[i];
    #1 chk("inv_shift_rows", rc_out, 128'h000d0a0704010e0b0805020f0c090603);
    rc_state = '0; rc_rk = {16{8'h52}} ^ {4{32'h8e4da1bc}}; rc_bypass = 1'b0;
    #1 chk("inv_mix_cols", rc_out, {4{32'hdb135345}});

    // C.1 vector
    expand(C1_KEY);
    chk("c1_sched_rk10", rk_sched[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("c1_model_enc", enc(C1_PT), C1_CT);
    @(negedge clk);
    bus.out_ready = 1'b1;
    send(C1_CT, ta);
    wait_done(td);
    chk("c1_latency", td - ta, 11);
    chk("c1_data", bus.data_out, C1_PT);
    n_blocks++;
    @(negedge clk);
    chk("c1_valid_drop", bus.out_valid, 0);

    // Appendix B vector with round-key index walk
    expand(B_KEY);
    chk("b_sched_rk10", rk_sched[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("b_model_enc", enc(B_PT), B_CT);
    chk("b_rk_idx_idle", bus.rk_idx, 10);
    send(B_CT, ta);
    for (int k = 9; k >= 0; k--) begin
      chk($sformatf("b_rk_idx_%0d", k), bus.rk_idx, k);
      @(negedge clk);
    end
    chk("b_out_valid", bus.out_valid, 1);
    chk("b_latency", cyc - ta, 11);
    chk("b_rk_idx_done", bus.rk_idx, 10);
    chk("b_data", bus.data_out, B_PT);
    n_blocks++;
    @(negedge clk);
    chk("b_valid_drop", bus.out_valid, 0);

    // Back-pressure with an ignored in_valid pulse
    expand(C1_KEY);
    bus.out_ready = 1'b0;
    send(C1_CT, ta);
    wait_done(td);
    for (int k = 0; k < 20; k++) begin
      chk("bp_data", bus.data_out, C1_PT);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      bus.in_valid = (k == 5);
      bus.data_in  = (k == 5) ? B_CT : '0;
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    n_blocks++;
    @(negedge clk);
    chk("bp_release_valid", bus.out_valid, 0);
    chk("bp_release_ready", bus.in_ready, 1);
    send(C1_CT, ta);
    wait_done(td);
    chk("b2b_data0", bus.data_out, C1_PT);
    send(C1_CT, ta2);
    wait_done(td2);
    chk("b2b_data1", bus.data_out, C1_PT);
    chk("b2b_accept_gap", ta2 - ta, 12);
    chk("b2b_done_gap", td2 - td, 12);
    n_blocks += 2;
    @(negedge clk);

    // Reset in the middle of a block
    expand(B_KEY);
    send(B_CT, ta);
    repeat (4) @(negedge clk);
    chk("mid_rk_idx_5", bus.rk_idx, 5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_data", bus.data_out, '0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_rk_idx", bus.rk_idx, 10);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(B_CT, ta);
    wait_done(td);
    chk("post_rst_b_data", bus.data_out, B_PT);
    n_blocks++;
    @(negedge clk);

    // Random keys / plaintexts with random output stalls
    for (int n = 0; n < 200; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      expand(key);
      ct = enc(pt);
      bus.out_ready = 1'b0;
      send(ct, ta);
      wait_done(td);
      chk("rnd_latency", td - ta, 11);
      chk("rnd_data", bus.data_out, pt);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk("rnd_hold_valid", bus.out_valid, 1);
        chk("rnd_hold_data", bus.data_out, pt);
      end
      bus.out_ready = 1'b1;
      n_blocks++;
      @(negedge clk);
      chk("rnd_valid_drop", bus.out_valid, 0);
      bus.out_ready = 1'b0;
    end

    repeat (2) @(negedge clk);
    chk("handshake_count", hs_cnt, n_blocks);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
